// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg
//   Shared definitions for the FSM MIPS core data memory:
//     - memory operation codes carried on the 'operation' port
//     - core FSM state codes seen on the 'state' port
//     - control FSM encoding of the data memory
//     - power-up contents of the low memory words
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_READ  = 2'b00,
        MEM_WRITE = 2'b01,
        MEM_IDLE  = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_op_e;

    localparam logic [2:0] STATE_IF     = 3'd0;
    localparam logic [2:0] STATE_ID     = 3'd1;
    localparam logic [2:0] STATE_EX     = 3'd2;
    localparam logic [2:0] STATE_ADDR   = 3'd3;
    localparam logic [2:0] STATE_MEM    = 3'd4;
    localparam logic [2:0] STATE_WB     = 3'd5;
    localparam logic [2:0] STATE_HALT   = 3'd6;
    localparam logic [2:0] STATE_OUTPUT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

    // Power-up value of memory word 'idx'; everything above word 2 starts at 0.
    function automatic logic [7:0] init_word(int unsigned idx);
        case (idx)
            0:       return 8'hEC;
            1:       return 8'h0A;
            2:       return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe
//   RD_LAT-deep register chain carrying read data and a valid bit.
//   A word entering on one edge leaves out_valid/out_data set RD_LAT-1
//   edges later, so the consumer registering it lands at RD_LAT.
//   Ports:
//     clk       in   clock
//     rst_n     in   asynchronous active-low reset (clears data and valid)
//     in_valid  in   word present at the input this cycle
//     in_data   in   word to carry
//     out_valid out  valid bit at the end of the chain
//     out_data  out  data at the end of the chain
module mem_rd_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_q [RD_LAT];
    logic [DATA_W-1:0] dat_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Parametrised data memory for the FSM MIPS core with a valid/ready
//   request channel, a one-cycle response strobe and an error flag.
//   Requests are taken only while the core sits in STATE_MEM.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset (memory array not reset)
//     state      in   current core FSM state
//     req_valid  in   request present
//     req_ready  out  request can be accepted this cycle (controller idle)
//     operation  in   00 READ, 01 WRITE, 10 IDLE, 11 reserved
//     address    in   word address
//     data_in    in   write data
//     data_out   out  read data, held until the next read response
//     resp_valid out  one-cycle completion pulse
//     resp_err   out  qualifies resp_valid: bad address or reserved op
module data_mem_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned RD_LAT    = 1,
    parameter logic [2:0]  STATE_MEM = 3'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        state,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        operation,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              resp_valid,
    output logic              resp_err
);

    import data_mem_ctrl_pkg::*;

    localparam int unsigned CNT_W = 2;

    ctrl_state_e       fsm_q, fsm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q;
    logic              rd_err_q;

    mem_op_e           op;
    logic              addr_ok;
    logic              accept;
    logic              op_err;
    logic              wr_en;
    logic              rd_good;

    logic [DATA_W-1:0] mem_view [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_dat;

    assign op      = mem_op_e'(operation);
    assign addr_ok = (32'(address) < DEPTH);
    assign accept  = req_valid && (fsm_q == IDLE) && (state == STATE_MEM) && (op != MEM_IDLE);
    assign op_err  = (op == MEM_RSVD) || !addr_ok;
    assign wr_en   = accept && (op == MEM_WRITE) && addr_ok;
    assign rd_good = accept && (op == MEM_READ) && addr_ok;

    // One register per word so each can carry its own power-up value;
    // the array is deliberately left out of the reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [DATA_W-1:0] word_q = DATA_W'(init_word(g));

        always_ff @(posedge clk) begin
            if (wr_en && (32'(address) == 32'(g))) begin
                word_q <= data_in;
            end
        end

        assign mem_view[g] = word_q;
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(address) == i) begin
                rd_word = mem_view[i];
            end
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_good),
        .in_data   (rd_word),
        .out_valid (pipe_vld),
        .out_data  (pipe_dat)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            if (accept) begin
                err_q    <= op_err;
                rd_err_q <= (op == MEM_READ) && !addr_ok;
            end
        end
    end

    // Next-state logic: only good reads wait the full read latency,
    // everything else (writes, errors) responds one cycle after accept.
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    fsm_d = WAIT;
                    cnt_d = rd_good ? CNT_W'(RD_LAT - 1) : '0;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    fsm_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (fsm_q == IDLE);
        resp_valid = (fsm_q == RESP);
        resp_err   = (fsm_q == RESP) && err_q;
    end

    // The pipe output arrives on the same edge the FSM enters RESP; a
    // bad-address read has no pipe entry and clears data_out on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (pipe_vld) begin
            data_out <= pipe_dat;
        end else if ((fsm_q == WAIT) && (cnt_q == '0) && rd_err_q) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    import data_mem_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] state;
    logic       req_valid;
    logic [1:0] operation;
    logic [7:0] address;
    logic [7:0] data_in;

    logic [2:0] rdy, rv, re;
    logic [7:0] dout [3];

    always #5 clk = ~clk;

    // Three instances share the request channel; each differs only in read latency.
    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(3), .RD_LAT(1), .STATE_MEM(3'd4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .state(state), .req_valid(req_valid), .req_ready(rdy[0]),
        .operation(operation), .address(address), .data_in(data_in), .data_out(dout[0]),
        .resp_valid(rv[0]), .resp_err(re[0]));
    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(3), .RD_LAT(3), .STATE_MEM(3'd4)) u_l3 (
        .clk(clk), .rst_n(rst_n), .state(state), .req_valid(req_valid), .req_ready(rdy[1]),
        .operation(operation), .address(address), .data_in(data_in), .data_out(dout[1]),
        .resp_valid(rv[1]), .resp_err(re[1]));
    data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(3), .RD_LAT(4), .STATE_MEM(3'd4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .state(state), .req_valid(req_valid), .req_ready(rdy[2]),
        .operation(operation), .address(address), .data_in(data_in), .data_out(dout[2]),
        .resp_valid(rv[2]), .resp_err(re[2]));

    // Edge counter: at a falling edge, cyc is the index of the last rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, one per instance: memory image, visible data_out,
    // and the single outstanding request (response edge, error, data update).
    int         lat_tab [3] = '{1, 3, 4};
    logic [7:0] mref    [3][3];
    logic [7:0] dref    [3];
    int         exp_cyc [3];
    int         free_at [3];
    logic       exp_err [3];
    logic       exp_upd [3];
    logic [7:0] exp_dat [3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            exp_cyc[k] = -1;
            free_at[k] = 0;
            dref[k]    = 8'h00;
            exp_err[k] = 1'b0;
            exp_upd[k] = 1'b0;
            exp_dat[k] = 8'h00;
        end
    endtask

    // Present a request for one cycle starting at a falling edge and record
    // what each instance should do with it on the next rising edge.
    task automatic send(input logic [2:0] st, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] d);
        int   e;
        logic good;
        logic err;
        int   lat;
        state     = st;
        operation = op;
        address   = a;
        data_in   = d;
        req_valid = 1'b1;
        e = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (rst_n && (e >= free_at[k]) && (st == STATE_MEM) && (op != MEM_IDLE)) begin
                good = (a < 8'd3);
                err  = (op == MEM_RSVD) || !good;
                lat  = (op == MEM_READ && !err) ? lat_tab[k] : 1;
                if (op == MEM_WRITE && good) mref[k][a[1:0]] = d;
                exp_upd[k] = (op == MEM_READ);
                exp_dat[k] = (op == MEM_READ && good) ? mref[k][a[1:0]] : 8'h00;
                exp_err[k] = err;
                exp_cyc[k] = e + lat;
                free_at[k] = e + lat + 2;
            end
        end
    endtask

    // Advance n cycles, comparing every instance's outputs at each falling edge.
    task automatic watch(input int n);
        logic e_rv;
        logic e_rdy;
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
            operation = MEM_IDLE;
            for (int k = 0; k < 3; k++) begin
                e_rv = (exp_cyc[k] == cyc);
                if (e_rv && exp_upd[k]) dref[k] = exp_dat[k];
                e_rdy = (cyc + 1 >= free_at[k]);
                n_cmp++;
                if (rv[k] !== e_rv) begin
                    n_bad++;
                    $display("FAIL resp_valid[%0d] cyc %0d: got %b want %b", k, cyc, rv[k], e_rv);
                end
                n_cmp++;
                if (re[k] !== (e_rv & exp_err[k])) begin
                    n_bad++;
                    $display("FAIL resp_err[%0d] cyc %0d: got %b want %b", k, cyc, re[k], e_rv & exp_err[k]);
                end
                n_cmp++;
                if (dout[k] !== dref[k]) begin
                    n_bad++;
                    $display("FAIL data_out[%0d] cyc %0d: got %h want %h", k, cyc, dout[k], dref[k]);
                end
                n_cmp++;
                if (rdy[k] !== e_rdy) begin
                    n_bad++;
                    $display("FAIL req_ready[%0d] cyc %0d: got %b want %b", k, cyc, rdy[k], e_rdy);
                end
            end
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        watch(n);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_cmp++;
        if (rdy !== 3'b111 || rv !== 3'b000 || re !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy=%b rv=%b re=%b want 111/000/000", rdy, rv, re);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_dout[%0d]: got %h want 00", k, dout[k]);
            end
        end
        watch(1);
    endtask

    task automatic test_read_latency();
        send(STATE_MEM, MEM_READ, 8'd1, 8'h00);
        watch(7);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 8'h0A) begin
                n_bad++;
                $display("FAIL read_addr1[%0d]: got %h want 0a", k, dout[k]);
            end
        end
        send(STATE_MEM, MEM_READ, 8'd0, 8'h00);
        watch(7);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 8'hEC) begin
                n_bad++;
                $display("FAIL read_addr0[%0d]: got %h want ec", k, dout[k]);
            end
        end
    endtask

    task automatic test_write_read();
        send(STATE_MEM, MEM_WRITE, 8'd2, 8'h5A);
        watch(4);
        send(STATE_MEM, MEM_READ, 8'd2, 8'h00);
        watch(7);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 8'h5A) begin
                n_bad++;
                $display("FAIL write_then_read[%0d]: got %h want 5a", k, dout[k]);
            end
        end
    endtask

    task automatic test_busy_write();
        send(STATE_MEM, MEM_READ, 8'd0, 8'h00);
        watch(1);
        send(STATE_MEM, MEM_WRITE, 8'd0, 8'h99);
        watch(7);
        send(STATE_MEM, MEM_READ, 8'd0, 8'h00);
        watch(7);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 8'hEC) begin
                n_bad++;
                $display("FAIL busy_write_dropped[%0d]: got %h want ec", k, dout[k]);
            end
        end
    endtask

    task automatic test_errors();
        send(STATE_MEM, MEM_READ, 8'd7, 8'h00);
        watch(4);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 8'h00) begin
                n_bad++;
                $display("FAIL bad_read_zero[%0d]: got %h want 00", k, dout[k]);
            end
        end
        send(STATE_MEM, MEM_WRITE, 8'd3, 8'h77);
        watch(4);
        for (int a = 0; a < 3; a++) begin
            send(STATE_MEM, MEM_READ, 8'(a), 8'h00);
            watch(7);
        end
    endtask

    task automatic test_gating();
        send(STATE_MEM, MEM_READ, 8'd1, 8'h00);
        watch(7);
        send(STATE_EX, MEM_READ, 8'd0, 8'h00);
        watch(7);
        send(STATE_MEM, MEM_IDLE, 8'd0, 8'h00);
        watch(7);
        send(STATE_MEM, MEM_RSVD, 8'd0, 8'h33);
        watch(4);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (dout[k] !== 8'h0A) begin
                n_bad++;
                $display("FAIL gating_dout_held[%0d]: got %h want 0a", k, dout[k]);
            end
        end
    endtask

    task automatic test_reset_midop();
        send(STATE_MEM, MEM_WRITE, 8'd1, 8'hC3);
        watch(4);
        send(STATE_MEM, MEM_READ, 8'd1, 8'h00);
        watch(3);
        apply_reset(2);
        watch(8);
        n_cmp++;
        if (rdy !== 3'b111) begin
            n_bad++;
            $display("FAIL reset_midop_ready: got %b want 111", rdy);
        end
        send(STATE_MEM, MEM_READ, 8'd1, 8'h00);
        watch(7);
    endtask

    task automatic test_random();
        logic [2:0] st;
        logic [1:0] op;
        for (int i = 0; i < 80; i++) begin
            st = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : STATE_MEM;
            op = 2'($urandom_range(0, 3));
            send(st, op, 8'($urandom_range(0, 7)), 8'($urandom));
            watch($urandom_range(1, 7));
        end
        watch(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        state     = STATE_MEM;
        req_valid = 1'b0;
        operation = MEM_IDLE;
        address   = 8'h00;
        data_in   = 8'h00;
        for (int k = 0; k < 3; k++) begin
            mref[k][0] = 8'hEC;
            mref[k][1] = 8'h0A;
            mref[k][2] = 8'h02;
        end
        model_reset();

        test_reset();
        test_read_latency();
        test_write_read();
        test_busy_write();
        test_errors();
        test_gating();
        test_reset_midop();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
